// File: rtl/pcseq_pkg.sv
// Shared types and constants for the pc_sequencer control FSM.
// Build option: PCSEQ_STEP_EN adds single-step support from HALT.
package pcseq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_BRANCH = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [15:0] HALT_WORD = 16'h0000;
    localparam logic [3:0]  OP_BCOND  = 4'hC;
    localparam logic [3:0]  OP_EXT    = 4'h4;

    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STORE = 4'h4;
    localparam logic [3:0] EXT_JCOND = 4'hC;

    localparam logic [3:0] CC_EQ = 4'd0;
    localparam logic [3:0] CC_NE = 4'd1;
    localparam logic [3:0] CC_CS = 4'd2;
    localparam logic [3:0] CC_CC = 4'd3;
    localparam logic [3:0] CC_HI = 4'd4;
    localparam logic [3:0] CC_LS = 4'd5;
    localparam logic [3:0] CC_GT = 4'd6;
    localparam logic [3:0] CC_LE = 4'd7;
    localparam logic [3:0] CC_FS = 4'd8;
    localparam logic [3:0] CC_FC = 4'd9;
    localparam logic [3:0] CC_LO = 4'd10;
    localparam logic [3:0] CC_HS = 4'd11;
    localparam logic [3:0] CC_LT = 4'd12;
    localparam logic [3:0] CC_GE = 4'd13;
    localparam logic [3:0] CC_UC = 4'd14;
    localparam logic [3:0] CC_NV = 4'd15;

    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

endpackage

// File: rtl/pcseq_cond.sv
// Branch condition evaluator: condition code and ALU flags to taken.
// Purely combinational so a pipelined core can reuse it as is.
module pcseq_cond
    import pcseq_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       taken
);

    logic c, l, f, z, n;

    assign c = flags[FLAG_C];
    assign l = flags[FLAG_L];
    assign f = flags[FLAG_F];
    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            CC_EQ: taken = z;
            CC_NE: taken = !z;
            CC_CS: taken = c;
            CC_CC: taken = !c;
            CC_HI: taken = l;
            CC_LS: taken = !l;
            CC_GT: taken = n;
            CC_LE: taken = !n;
            CC_FS: taken = f;
            CC_FC: taken = !f;
            CC_LO: taken = !l && !z;
            CC_HS: taken = l || z;
            CC_LT: taken = !n && !z;
            CC_GE: taken = n || z;
            CC_UC: taken = 1'b1;
            CC_NV: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving pc and datapath strobes.
// Build option: PCSEQ_STEP_EN adds the step port and single-step from HALT.
module pc_sequencer
    import pcseq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    input  logic        dmem_ready,
    input  logic [4:0]  flags,
    input  logic [9:0]  rtarget,
    input  logic        run,
`ifdef PCSEQ_STEP_EN
    input  logic        step,
`endif
    output logic        imem_req,
    output logic [15:0] ir,
    output logic        pc_en,
    output logic        branch_en,
    output logic        jump_en,
    output logic [9:0]  branch_offset,
    output logic [9:0]  jump_addr,
    output logic [3:0]  rtarget_sel,
    output logic        rf_we,
    output logic        flags_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        halted,
    output logic [2:0]  state
);

    state_t      state_q, state_d;
    logic [15:0] ir_q;
    logic        done;
    logic        taken;
    logic        is_bcond, is_ext;
    logic        is_load, is_store, is_jcond;
    logic        leave_halt;

`ifdef PCSEQ_STEP_EN
    logic step_q;
    logic step_go;
    assign step_go = step && !run;
`else
    localparam logic step_q  = 1'b0;
    localparam logic step_go = 1'b0;
`endif

    assign is_bcond = ir_q[15:12] == OP_BCOND;
    assign is_ext   = ir_q[15:12] == OP_EXT;
    assign is_load  = is_ext && ir_q[7:4] == EXT_LOAD;
    assign is_store = is_ext && ir_q[7:4] == EXT_STORE;
    assign is_jcond = is_ext && ir_q[7:4] == EXT_JCOND;

    assign leave_halt = run || step_go;

    pcseq_cond u_cond (
        .cond  (ir_q[11:8]),
        .flags (flags),
        .taken (taken)
    );

    assign ir            = ir_q;
    assign branch_offset = {{2{ir_q[7]}}, ir_q[7:0]};
    assign jump_addr     = rtarget;
    assign rtarget_sel   = ir_q[3:0];
    assign halted        = state_q == ST_HALT;
    assign state         = state_q;

    // Next state; done marks the final cycle of an instruction.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            ST_FETCH:
                if (imem_valid) state_d = ST_DECODE;
            ST_DECODE:
                if (ir_q == HALT_WORD) state_d = ST_HALT;
                else if (is_bcond || is_jcond) state_d = ST_BRANCH;
                else if (is_load || is_store) state_d = ST_MEM;
                else state_d = ST_EXEC;
            ST_EXEC:   done = 1'b1;
            ST_MEM:    done = dmem_ready;
            ST_BRANCH: done = 1'b1;
            ST_HALT:
                if (leave_halt) state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
        if (done) state_d = step_q ? ST_HALT : ST_FETCH;
    end

    always_comb begin
        imem_req  = 1'b0;
        pc_en     = 1'b0;
        branch_en = 1'b0;
        jump_en   = 1'b0;
        rf_we     = 1'b0;
        flags_we  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_FETCH:  imem_req = 1'b1;
                ST_DECODE: ;
                ST_EXEC: begin
                    rf_we    = 1'b1;
                    flags_we = 1'b1;
                    pc_en    = 1'b1;
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    if (dmem_ready) begin
                        pc_en = 1'b1;
                        rf_we = is_load;
                    end
                end
                ST_BRANCH: begin
                    if (!taken) pc_en = 1'b1;
                    else if (is_bcond) branch_en = 1'b1;
                    else jump_en = 1'b1;
                end
                ST_HALT:   pc_en = leave_halt;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH && imem_valid) ir_q <= imem_data;
        end
    end

`ifdef PCSEQ_STEP_EN
    // A stepped HALT word also counts as the one stepped instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= 1'b0;
        end else if (state_q == ST_HALT && step_go) begin
            step_q <= 1'b1;
        end else if (done) begin
            step_q <= 1'b0;
        end else if (state_q == ST_DECODE && ir_q == HALT_WORD) begin
            step_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Define PCSEQ_STEP_EN to also exercise single-step.
module tb_pc_sequencer;

    localparam logic [7:0] S_NONE = 8'h00;
    localparam logic [7:0] S_REQ  = 8'h80;
    localparam logic [7:0] S_PC   = 8'h40;
    localparam logic [7:0] S_BR   = 8'h20;
    localparam logic [7:0] S_JMP  = 8'h10;
    localparam logic [7:0] S_RF   = 8'h08;
    localparam logic [7:0] S_FL   = 8'h04;
    localparam logic [7:0] S_DREQ = 8'h02;
    localparam logic [7:0] S_DWE  = 8'h01;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        dmem_ready;
    logic [4:0]  flags;
    logic [9:0]  rtarget;
    logic        run;
`ifdef PCSEQ_STEP_EN
    logic        step;
`endif
    logic        imem_req;
    logic [15:0] ir;
    logic        pc_en, branch_en, jump_en;
    logic [9:0]  branch_offset;
    logic [9:0]  jump_addr;
    logic [3:0]  rtarget_sel;
    logic        rf_we, flags_we, dmem_req, dmem_we;
    logic        halted;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    wire [7:0] strobes = {imem_req, pc_en, branch_en, jump_en,
                          rf_we, flags_we, dmem_req, dmem_we};

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .imem_valid    (imem_valid),
        .imem_data     (imem_data),
        .dmem_ready    (dmem_ready),
        .flags         (flags),
        .rtarget       (rtarget),
        .run           (run),
`ifdef PCSEQ_STEP_EN
        .step          (step),
`endif
        .imem_req      (imem_req),
        .ir            (ir),
        .pc_en         (pc_en),
        .branch_en     (branch_en),
        .jump_en       (jump_en),
        .branch_offset (branch_offset),
        .jump_addr     (jump_addr),
        .rtarget_sel   (rtarget_sel),
        .rf_we         (rf_we),
        .flags_we      (flags_we),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .halted        (halted),
        .state         (state)
    );

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] word, input int waits);
        for (int i = 0; i < waits; i++) begin
            imem_valid = 1'b0;
            #1;
            check("fetch_wait_state", 16'(state), 16'd0);
            check("fetch_wait_strobes", 16'(strobes), 16'(S_REQ));
            cyc();
        end
        imem_valid = 1'b1;
        imem_data  = word;
        #1;
        check("fetch_state", 16'(state), 16'd0);
        check("fetch_strobes", 16'(strobes), 16'(S_REQ));
        cyc();
        imem_valid = 1'b0;
        imem_data  = 16'hDEAD;
        #1;
        check("decode_state", 16'(state), 16'd1);
        check("decode_ir", ir, word);
        check("decode_strobes", 16'(strobes), 16'(S_NONE));
        cyc();
    endtask

    task automatic do_br(input logic [15:0] word, input logic [4:0] fl,
                         input logic [7:0] exp);
        fetch(word, 0);
        flags = fl;
        #1;
        check("branch_state", 16'(state), 16'd4);
        check("branch_strobes", 16'(strobes), 16'(exp));
        cyc();
    endtask

    initial begin
        reset      = 1'b1;
        imem_valid = 1'b1;
        imem_data  = 16'h1234;
        dmem_ready = 1'b0;
        flags      = 5'b0;
        rtarget    = 10'h155;
        run        = 1'b0;
`ifdef PCSEQ_STEP_EN
        step       = 1'b0;
`endif
        cyc();
        check("reset_strobes_1", 16'(strobes), 16'(S_NONE));
        cyc();
        check("reset_state", 16'(state), 16'd0);
        check("reset_ir", ir, 16'h0000);
        check("reset_strobes_2", 16'(strobes), 16'(S_NONE));
        reset = 1'b0;

        // ALU instruction, zero-wait fetch
        fetch(16'h1234, 0);
        #1;
        check("alu_state", 16'(state), 16'd2);
        check("alu_strobes", 16'(strobes), 16'(S_PC | S_RF | S_FL));
        cyc();

        // Branches
        do_br(16'hC0FE, 5'b00010, S_BR);
        check("beq_offset", 16'(branch_offset), 16'h03FE);
        do_br(16'hC0FE, 5'b00000, S_PC);
        do_br(16'hC201, 5'b10000, S_BR);
        check("bcs_offset", 16'(branch_offset), 16'h0001);
        do_br(16'hCA05, 5'b00000, S_BR);
        do_br(16'hCA05, 5'b01000, S_PC);
        do_br(16'hCC01, 5'b00001, S_PC);
        do_br(16'hCD01, 5'b00010, S_BR);
        do_br(16'hCF01, 5'b11111, S_PC);
        do_br(16'hC780, 5'b00000, S_BR);
        check("ble_offset", 16'(branch_offset), 16'h0380);

        // Jcond
        do_br(16'h4EC5, 5'b00000, S_JMP);
        check("jmp_sel", 16'(rtarget_sel), 16'h0005);
        check("jmp_addr", 16'(jump_addr), 16'h0155);
        do_br(16'h4FC5, 5'b11111, S_PC);

        // Load with three wait cycles; stray imem_valid ignored
        fetch(16'h4203, 1);
        for (int i = 0; i < 3; i++) begin
            imem_valid = (i == 1);
            #1;
            check("load_wait_state", 16'(state), 16'd3);
            check("load_wait_strobes", 16'(strobes), 16'(S_DREQ));
            cyc();
        end
        imem_valid = 1'b0;
        dmem_ready = 1'b1;
        #1;
        check("load_done_strobes", 16'(strobes), 16'(S_DREQ | S_PC | S_RF));
        cyc();
        dmem_ready = 1'b0;

        // Store completing at once, imem_valid also high
        fetch(16'h4243, 0);
        dmem_ready = 1'b1;
        imem_valid = 1'b1;
        #1;
        check("store_strobes", 16'(strobes), 16'(S_DREQ | S_DWE | S_PC));
        cyc();
        dmem_ready = 1'b0;
        imem_valid = 1'b0;

        // Other ext code behaves as ALU
        fetch(16'h4213, 0);
        #1;
        check("ext_alu_state", 16'(state), 16'd2);
        check("ext_alu_strobes", 16'(strobes), 16'(S_PC | S_RF | S_FL));
        cyc();

        // Reset during a store wait
        fetch(16'h4243, 0);
        #1;
        check("store_wait_strobes", 16'(strobes), 16'(S_DREQ | S_DWE));
        cyc();
        reset      = 1'b1;
        dmem_ready = 1'b1;
        #1;
        check("midmem_reset_strobes", 16'(strobes), 16'(S_NONE));
        cyc();
        check("midmem_reset_state", 16'(state), 16'd0);
        check("midmem_reset_ir", ir, 16'h0000);
        reset      = 1'b0;
        dmem_ready = 1'b0;

        // HALT and run
        fetch(16'h0000, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("halt_state", 16'(state), 16'd5);
            check("halt_flag", 16'(halted), 16'd1);
            check("halt_strobes", 16'(strobes), 16'(S_NONE));
            cyc();
        end
        run = 1'b1;
        #1;
        check("run_strobes", 16'(strobes), 16'(S_PC));
        cyc();
        run = 1'b0;
        #1;
        check("run_state", 16'(state), 16'd0);
        check("run_halted", 16'(halted), 16'd0);

`ifdef PCSEQ_STEP_EN
        fetch(16'h0000, 0);
        check("step_halt_state", 16'(state), 16'd5);
        step = 1'b1;
        #1;
        check("step_strobes", 16'(strobes), 16'(S_PC));
        cyc();
        step = 1'b0;
        fetch(16'h1234, 0);
        #1;
        check("step_exec_strobes", 16'(strobes), 16'(S_PC | S_RF | S_FL));
        cyc();
        check("step_rehalt_state", 16'(state), 16'd5);
        check("step_rehalt_flag", 16'(halted), 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle control FSM that sequences the `pc` register and the instruction register. It fetches a 16-bit instruction over a request/valid handshake, classifies it, and evaluates branch conditions against the ALU flags. In the final cycle of every instruction it issues exactly one of `pc_en`, `branch_en` or `jump_en`. It sits between instruction memory, the ALU/register-file datapath and `pc`, and drives all of their write strobes.

## Interface
- No parameters; widths fixed by `pcseq_pkg`.
- `clk  in  1`  rising-edge clock.
- `reset  in  1`  synchronous, active-high reset.
- `imem_valid  in  1`  instruction word on `imem_data` is valid this cycle.
- `imem_data  in  16`  instruction memory read data.
- `dmem_ready  in  1`  data memory completes the access this cycle.
- `flags  in  5`  ALU flags `{C,L,F,Z,N}` (bit 4 down to bit 0).
- `rtarget  in  10`  register-file read data for the jump target.
- `run  in  1`  leave HALT.
- `step  in  1`  single-step from HALT; present only with `PCSEQ_STEP_EN`.
- `imem_req  out  1`  fetch request.
- `ir  out  16`  instruction register.
- `pc_en, branch_en, jump_en  out  1`  drive the `pc` strobes of the same names.
- `branch_offset  out  10`  `ir[7:0]` sign-extended to 10 bits.
- `jump_addr  out  10`  equals `rtarget`.
- `rtarget_sel  out  4`  equals `ir[3:0]`.
- `rf_we, flags_we, dmem_req, dmem_we  out  1`  datapath strobes.
- `halted  out  1`  FSM is in HALT.
- `state  out  3`  current state encoding.

## Operation
- **States:** FETCH, DECODE, EXEC, MEM, BRANCH, HALT.
- **FETCH**
  - `imem_req=1` until `imem_valid`.
  - On a cycle with `imem_valid=1`: latch `ir` from `imem_data` and go to DECODE.
- **DECODE** (no strobes asserted):
  - `ir==HALT_WORD` (16'h0000) → HALT.
  - `ir[15:12]==OP_BCOND` (4'hC) → BRANCH.
  - `ir[15:12]==OP_EXT` (4'h4):
    - `ir[7:4]==4'hC` (Jcond) → BRANCH.
    - `ir[7:4]==4'h0` (load) → MEM.
    - `ir[7:4]==4'h4` (store) → MEM.
  - Anything else → EXEC.
- **EXEC:** `rf_we=1`, `flags_we=1`, `pc_en=1` for one cycle → FETCH.
- **MEM**
  - `dmem_req=1` until `dmem_ready`; `dmem_we=1` throughout for a store.
  - On the `dmem_ready` cycle: `pc_en=1`, plus `rf_we=1` for a load → FETCH.
- **BRANCH**
  - Condition taken from `ir[11:8]`:
    - EQ 0: Z. NE 1: !Z.
    - CS 2: C. CC 3: !C.
    - HI 4: L. LS 5: !L.
    - GT 6: N. LE 7: !N.
    - FS 8: F. FC 9: !F.
    - LO 10: !L&!Z. HS 11: L|Z.
    - LT 12: !N&!Z. GE 13: N|Z.
    - UC 14: 1. 15: 0.
  - Taken Bcond → `branch_en=1`. Taken Jcond → `jump_en=1`. Not taken → `pc_en=1`. Then → FETCH.
- **HALT:** `halted=1`. When `run=1`: `pc_en=1` → FETCH.
- **Strobe invariant:** at most one of `pc_en`/`branch_en`/`jump_en` is high in any cycle; exactly one is high per completed instruction.
- **Flag sampling:** `flags` is sampled in BRANCH (combinational). The previous instruction's `flags_we` has already committed by then.

## Timing
- **Reset:** next state is FETCH; `ir=0`. While `reset=1`, all strobes and `imem_req` are forced to 0 combinationally.
- **Reset mid-instruction:** the instruction is abandoned. No strobes fire and no PC update occurs beyond `pc`'s own reset.
- **Latency:**
  - ALU instruction or branch: 3 cycles with zero-wait fetch.
  - Load/store: 3 cycles plus the `dmem_ready` wait.
  - HALT exit: 1 cycle after `run`.
- **Registered vs. combinational:** `ir` and state are registered. All other outputs are decoded combinationally from state, `ir`, `flags` and the handshake inputs.
- **`imem_valid` outside FETCH** is ignored.
- **`dmem_ready` and `imem_valid` together in the same cycle:** only the one relevant to the current state acts.

## Configuration
- **`PCSEQ_STEP_EN` defined:**
  - `step` port exists.
  - In HALT, `step=1` with `run=0` sets an internal step flag and issues `pc_en` → FETCH. The next instruction executes.
  - When that instruction's final cycle completes, the FSM enters HALT instead of FETCH.
  - `run` and `step` together: `run` wins and the step flag stays clear.
  - Reset clears the step flag.
- **`PCSEQ_STEP_EN` undefined:** no `step` port and no step flag; HALT exits only on `run`.

## Structure
- **`pcseq_pkg`:** state enum, `OP_BCOND`, `OP_EXT`, ext codes, `HALT_WORD`, condition-code constants, flag bit indices.
- **Sub-module `pcseq_cond`:** combinational `(cond[3:0], flags[4:0]) → taken`. Shareable with a future pipelined core.

## Test plan
- **Reset then ALU instruction:** hold reset 2 cycles; `imem_valid=1` with 16'h1234 → `pc_en` exactly once, in cycle 3 after fetch; `rf_we=flags_we=1` in the same cycle.
- **BEQ with Z=1:** `ir=16'hC0FE` → `branch_en=1`, `branch_offset=10'h3FE`. With Z=0 → `pc_en=1`, `branch_en=0`.
- **Jcond UC:** `ir=16'h4EC5`, `rtarget=10'h155` → `rtarget_sel=5`, `jump_en=1`, `jump_addr=10'h155`.
- **Load with 3 wait cycles:** `ir=16'h4203`, `dmem_ready` high on the 4th MEM cycle → `dmem_req` high for 4 cycles, `dmem_we=0`; `rf_we` and `pc_en` on the last of those cycles only.
- **HALT and run:** fetch 16'h0000 → `halted=1` indefinitely. Pulse `run` → `pc_en` that cycle, FETCH next.
- **Reset mid-MEM:** assert reset during a store wait → `dmem_req=0` and no strobes during reset; `state` is FETCH after. With `PCSEQ_STEP_EN`: `step` from HALT executes one instruction, then `halted=1` again.
